// File: rtl/fpcvt_pkg.sv
// fpcvt_pkg: constants and types shared by the FPCVT decoder and its helpers.
//   D_W     integer width produced by the decoder
//   E_W     exponent width of the packed float
//   F_W     significand width of the packed float
//   MAX_MAG largest magnitude a float can encode (15 << 7 = 1920)
//   fpcvt_state_e  decoder FSM state encoding
//   half_ulp()     half of one step at exponent e (used by the midpoint option)
package fpcvt_pkg;

   localparam int D_W = 12;
   localparam int E_W = 3;
   localparam int F_W = 4;
   localparam int MAX_MAG = ((1 << F_W) - 1) << ((1 << E_W) - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      SIGN  = 2'd2,
      DONE  = 2'd3
   } fpcvt_state_e;

   // Half of the step between adjacent floats at exponent e; zero when e==0.
   function automatic logic [D_W-1:0] half_ulp(input logic [E_W-1:0] e);
      logic [D_W-1:0] r;
      r = '0;
      if (e != '0) r = D_W'(1) << (e - 1'b1);
      return r;
   endfunction

endpackage

// File: rtl/fpcvt_decode_if.sv
// fpcvt_decode_if: float-in / integer-out handshake bundle of the decoder.
//   in_valid/in_ready   float {S,E,F} offered / accepted
//   out_valid/out_ready integer D offered / accepted
// Handshake rule on both sides: a transfer happens on a rising clk edge where
// valid && ready are both high; the producer holds its payload and valid
// stable until that edge, and ready may change freely while valid is low.
//   master: the side that supplies floats and consumes integers
//   slave : the decoder
interface fpcvt_decode_if;
   import fpcvt_pkg::*;

   logic           in_valid;
   logic           in_ready;
   logic           S;
   logic [E_W-1:0] E;
   logic [F_W-1:0] F;
   logic           out_valid;
   logic           out_ready;
   logic [D_W-1:0] D;

   modport master (
      output in_valid, S, E, F, out_ready,
      input  in_ready, out_valid, D
   );

   modport slave (
      input  in_valid, S, E, F, out_ready,
      output in_ready, out_valid, D
   );

endinterface

// File: rtl/fpcvt_negate.sv
// fpcvt_negate: combinational conditional two's-complement negation.
//   neg  1  negate when high
//   val  W  unsigned magnitude
//   res  W  val or -val, W-bit two's complement (0 stays 0)
module fpcvt_negate
   import fpcvt_pkg::*;
#(
   parameter int W = D_W
) (
   input  logic         neg,
   input  logic [W-1:0] val,
   output logic [W-1:0] res
);

   assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/fpcvt_decode.sv
// fpcvt_decode: turns an 8-bit float {S,E,F} (value (-1)^S * F * 2^E) back
// into a D_W-bit two's-complement integer, one left shift per clock.
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        fpcvt_decode_if.slave (in/out handshakes, S/E/F in, D out)
//   busy       FSM is not in IDLE
//   state_dbg  current FSM state
// Optional build macro FPCVT_DECODE_MIDPOINT_EN: when defined, the result is
// the midpoint of the encoder's rounding interval (adds 2^(E-1) for E>0).
module fpcvt_decode
   import fpcvt_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   fpcvt_decode_if.slave        bus,
   output logic                 busy,
   output fpcvt_state_e         state_dbg
);

   fpcvt_state_e   state, state_n;
   logic [D_W-1:0] mag, mag_n;
   logic [E_W-1:0] cnt, cnt_n;
   logic           sgn, sgn_n;
   logic           in_ready_q, in_ready_n;
   logic           out_valid_q, out_valid_n;
   logic [D_W-1:0] d_q, d_n;
   logic [D_W-1:0] mag_adj;
   logic [D_W-1:0] neg_res;

`ifdef FPCVT_DECODE_MIDPOINT_EN
   // Exponent kept from the accept edge; cnt has counted down to 0 by SIGN.
   logic [E_W-1:0] exp_r, exp_n;

   // A zero significand stays exactly zero so that +-0 still decodes to 0.
   assign mag_adj = (mag != '0) ? (mag + half_ulp(exp_r)) : mag;
`else
   assign mag_adj = mag;
`endif

   fpcvt_negate #(.W(D_W)) u_negate (
      .neg (sgn),
      .val (mag_adj),
      .res (neg_res)
   );

   always_comb begin
      state_n     = state;
      mag_n       = mag;
      cnt_n       = cnt;
      sgn_n       = sgn;
      out_valid_n = out_valid_q;
      d_n         = d_q;
`ifdef FPCVT_DECODE_MIDPOINT_EN
      exp_n       = exp_r;
`endif
      case (state)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               mag_n   = D_W'(bus.F);
               cnt_n   = bus.E;
               sgn_n   = bus.S;
`ifdef FPCVT_DECODE_MIDPOINT_EN
               exp_n   = bus.E;
`endif
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt == '0) begin
               state_n = SIGN;
            end else begin
               mag_n = mag << 1;
               cnt_n = cnt - 1'b1;
            end
         end
         SIGN: begin
            d_n         = neg_res;
            out_valid_n = 1'b1;
            state_n     = DONE;
         end
         DONE: begin
            if (out_valid_q && bus.out_ready) begin
               out_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      // Registered from the next state, so out_ready never reaches in_ready
      // combinationally.
      in_ready_n = (state_n == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mag         <= '0;
         cnt         <= '0;
         sgn         <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         d_q         <= '0;
`ifdef FPCVT_DECODE_MIDPOINT_EN
         exp_r       <= '0;
`endif
      end else begin
         state       <= state_n;
         mag         <= mag_n;
         cnt         <= cnt_n;
         sgn         <= sgn_n;
         in_ready_q  <= in_ready_n;
         out_valid_q <= out_valid_n;
         d_q         <= d_n;
`ifdef FPCVT_DECODE_MIDPOINT_EN
         exp_r       <= exp_n;
`endif
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.D         = d_q;
   assign busy          = (state != IDLE);
   assign state_dbg     = state;

endmodule

// File: tb/tb_fpcvt_decode.sv
// tb_fpcvt_decode: directed bench for fpcvt_decode with a per-cycle
// arithmetic model (expected integers in exp_q) and literal spot checks.
`timescale 1ns/1ps
module tb_fpcvt_decode;
   import fpcvt_pkg::*;

   logic         clk;
   logic         rst_n;
   logic         busy;
   fpcvt_state_e state_dbg;

   fpcvt_decode_if bus ();

   fpcvt_decode dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .busy      (busy),
      .state_dbg (state_dbg)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- model ----------------
   function automatic logic [11:0] model(input logic s, input int e, input int f);
      int v;
      v = f * (1 << e);
`ifdef FPCVT_DECODE_MIDPOINT_EN
      if (e > 0 && f != 0) v = v + (1 << (e - 1));
`endif
      if (s) v = -v;
      return v[11:0];
   endfunction

   // ---------------- scoreboard ----------------
   logic [11:0] exp_q[$];
   bit          pending = 0;
   int          due     = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         pending = 0;
         check("rst_out_valid", bus.out_valid, 0);
         check("rst_D", bus.D, 0);
         check("rst_in_ready", bus.in_ready, 1);
         check("rst_busy", busy, 0);
      end else begin
         check("out_valid", bus.out_valid, (pending && cyc >= due));
         check("in_ready", bus.in_ready, !pending);
         check("busy", busy, pending);
         if (bus.out_valid) begin
            if (exp_q.size() == 0) check("D_unexpected", 1, 0);
            else check("D", bus.D, exp_q[0]);
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            pending = 0;
         end else if (!pending && bus.in_valid) begin
            pending = 1;
            exp_q.push_back(model(bus.S, int'(bus.E), int'(bus.F)));
            due = cyc + 3 + int'(bus.E);
         end
      end
   end

   // ---------------- driver tasks ----------------
   // All tasks start and end at posedge+2.
   task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f);
      int n;
      n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #2;
         n++;
      end
      check("send_in_ready", bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.S = s;
      bus.E = e;
      bus.F = f;
      @(posedge clk); #2;
      bus.in_valid = 1'b0;
      bus.S = 1'($urandom_range(0, 1));
      bus.E = 3'($urandom_range(0, 7));
      bus.F = 4'($urandom_range(0, 15));
   endtask

   task automatic wait_result(input logic [11:0] exp_d, input int exp_lat, input string tag);
      int n;
      n = 0;
      while (!bus.out_valid && n < 40) begin
         @(posedge clk); #2;
         n++;
      end
      check({tag, "_latency"}, n, exp_lat);
      check({tag, "_D"}, bus.D, exp_d);
      if (bus.out_ready) begin
         @(posedge clk); #2;
         check({tag, "_in_ready_after"}, bus.in_ready, 1);
      end
   endtask

   // Round-to-nearest reference encoder for the round-trip sweep.
   task automatic encode(input int x, output logic s, output logic [2:0] e, output logic [3:0] f);
      int mag, ee, half;
      mag = (x < 0) ? -x : x;
      ee = 0;
      half = 0;
      while (((mag + half) >> ee) > 15) begin
         ee++;
         half = 1 << (ee - 1);
      end
      s = (x < 0);
      e = 3'(ee);
      f = 4'((mag + half) >> ee);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      bus.S = 1'b0;
      bus.E = '0;
      bus.F = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk); #2;

      // Basic and boundary vectors
      send(0, 0, 9);   wait_result(12'h009, 2, "basic");
`ifdef FPCVT_DECODE_MIDPOINT_EN
      send(0, 7, 15);  wait_result(12'h7C0, 9, "max_pos");
      send(1, 7, 15);  wait_result(12'h840, 9, "max_neg");
`else
      send(0, 7, 15);  wait_result(12'h780, 9, "max_pos");
      send(1, 7, 15);  wait_result(12'h880, 9, "max_neg");
`endif
      send(1, 4, 0);   wait_result(12'h000, 6, "neg_zero");
      send(0, 0, 0);   wait_result(12'h000, 2, "zero");

      // Reset in the middle of a conversion
      send(0, 5, 9);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_D", bus.D, 0);
      check("midrst_in_ready", bus.in_ready, 1);
      check("midrst_busy", busy, 0);
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #2;
`ifdef FPCVT_DECODE_MIDPOINT_EN
      send(0, 2, 5);   wait_result(12'h016, 4, "after_rst");
`else
      send(0, 2, 5);   wait_result(12'h014, 4, "after_rst");
`endif

      // Backpressure with an ignored in_valid
      bus.out_ready = 1'b0;
      send(1, 3, 12);
`ifdef FPCVT_DECODE_MIDPOINT_EN
      wait_result(12'hF9C, 5, "bp");
`else
      wait_result(12'hFA0, 5, "bp");
`endif
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #2;
         if (i == 2) begin
            bus.in_valid = 1'b1;
            bus.S = 1'b0;
            bus.E = 3'd1;
            bus.F = 4'd3;
         end
         if (i == 6) bus.in_valid = 1'b0;
`ifdef FPCVT_DECODE_MIDPOINT_EN
         check("bp_hold_D", bus.D, 12'hF9C);
`else
         check("bp_hold_D", bus.D, 12'hFA0);
`endif
         check("bp_hold_valid", bus.out_valid, 1);
         check("bp_hold_in_ready", bus.in_ready, 0);
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #2;
      check("bp_release_valid", bus.out_valid, 0);
      check("bp_release_in_ready", bus.in_ready, 1);
      check("bp_release_busy", busy, 0);

`ifndef FPCVT_DECODE_MIDPOINT_EN
      // Round trip through the reference encoder over the encodable range
      for (int x = -MAX_MAG; x <= MAX_MAG; x++) begin
         logic       s;
         logic [2:0] e;
         logic [3:0] f;
         int         n, r, diff, tol;
         bit         ok;
         encode(x, s, e, f);
         send(s, e, f);
         n = 0;
         while (!bus.out_valid && n < 40) begin
            @(posedge clk); #2;
            n++;
         end
         r = int'($signed(bus.D));
         diff = (r > x) ? (r - x) : (x - r);
         tol = (e == 0) ? 0 : (1 << (int'(e) - 1));
         ok = (n == int'(e) + 2) && (diff <= tol) &&
              ((x > 0 && r > 0) || (x < 0 && r < 0) || (x == 0 && r == 0));
         check("roundtrip", ok, 1);
         @(posedge clk); #2;
      end
`endif

      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      errors++;
      $display("FAIL watchdog: run still active at %0t, limit 1000000ns", $time);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog expired");
   end

endmodule
